// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI pin and local TX/RX handshake bundle for spi_slave (overrun only with SPI_SLAVE_OVERRUN_EN)
interface spi_slave_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  sclk;
    logic                  cs_n;
    logic                  mosi;
    logic                  miso;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ack;
    logic                  busy;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic                  overrun;
`endif

    modport slave (
        input  sclk, cs_n, mosi, tx_data, tx_valid, rx_ack,
        output miso, tx_ready, rx_data, rx_valid, busy
`ifdef SPI_SLAVE_OVERRUN_EN
        , output overrun
`endif
    );

    modport master (
        output sclk, cs_n, mosi, tx_data, tx_valid, rx_ack,
        input  miso, tx_ready, rx_data, rx_valid, busy
`ifdef SPI_SLAVE_OVERRUN_EN
        , input overrun
`endif
    );
endinterface

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampled SPI slave endpoint; SPI_SLAVE_OVERRUN_EN adds a sticky overrun flag
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int CPOL        = 1,
    parameter int CPHA        = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    spi_slave_if.slave bus
);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;
    localparam logic       IDLE_LVL  = (CPOL != 0);
    localparam int         CNT_W     = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sclk_prev;
    logic                   cs_prev;
    logic                   cs_armed;

    logic [0:0]             state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_WIDTH-2:0]  rx_shift;
    logic [DATA_WIDTH-1:0]  rx_word;
    logic [DATA_WIDTH-1:0]  tx_shift;
    logic [DATA_WIDTH-1:0]  tx_buf;
    logic                   tx_full;
    logic                   init_done;
    logic [DATA_WIDTH-1:0]  rx_data_r;
    logic                   rx_valid_r;

    logic lead_edge;
    logic trail_edge;
    logic sample_edge;
    logic shift_edge;
    logic cs_fall;
    logic cs_rise;
    logic active;
    logic word_done;
    logic tx_load;
    logic tx_write;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // cs_n chain and history reset low so that only a genuinely observed high-then-low
    // sequence opens a frame; a frame already running across reset is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= {SYNC_STAGES{IDLE_LVL}};
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_prev <= IDLE_LVL;
            cs_prev   <= 1'b0;
            cs_armed  <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
            if (cs_s) begin
                cs_armed <= 1'b1;
            end
        end
    end

    assign lead_edge   = (sclk_prev == IDLE_LVL) && (sclk_s != IDLE_LVL);
    assign trail_edge  = (sclk_prev != IDLE_LVL) && (sclk_s == IDLE_LVL);
    assign sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
    assign shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;
    assign cs_fall     = cs_prev & ~cs_s;
    assign cs_rise     = ~cs_prev & cs_s;
    assign active      = (state == ST_ACTIVE);
    assign word_done   = active && !cs_rise && sample_edge && (bit_cnt == LAST_BIT);
    assign tx_load     = (!active && cs_fall) || word_done;
    assign tx_write    = bus.tx_valid && bus.tx_ready;
    assign rx_word     = {rx_shift, mosi_s};

    // Frame FSM, bit counter and the two shift registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
        end else begin
            if (!active) begin
                if (cs_fall) begin
                    state   <= ST_ACTIVE;
                    bit_cnt <= '0;
                end
            end else if (cs_rise) begin
                state   <= ST_IDLE;
                bit_cnt <= '0;
            end else if (sample_edge) begin
                rx_shift <= rx_word[DATA_WIDTH-2:0];
                bit_cnt  <= word_done ? '0 : bit_cnt + CNT_W'(1);
            end else if (shift_edge && (bit_cnt != '0)) begin
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
            // An empty holding buffer at a word boundary sends all ones.
            if (tx_load) begin
                tx_shift <= tx_full ? tx_buf : '1;
            end
        end
    end

    // TX holding buffer; a write in the same cycle as a transfer refills it
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_buf    <= '0;
            tx_full   <= 1'b0;
            init_done <= 1'b0;
        end else begin
            init_done <= 1'b1;
            if (tx_write) begin
                tx_buf  <= bus.tx_data;
                tx_full <= 1'b1;
            end else if (tx_load && tx_full) begin
                tx_full <= 1'b0;
            end
        end
    end

    // Received word register; a new word wins over a simultaneous acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_r  <= '0;
            rx_valid_r <= 1'b0;
        end else if (word_done) begin
            rx_data_r  <= rx_word;
            rx_valid_r <= 1'b1;
        end else if (bus.rx_ack) begin
            rx_valid_r <= 1'b0;
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic overrun_r;

    // Sticky flag for a word landing on an unread word; only reset clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_r <= 1'b0;
        end else if (word_done && rx_valid_r && !bus.rx_ack) begin
            overrun_r <= 1'b1;
        end
    end

    assign bus.overrun = overrun_r;
`endif

    assign bus.miso     = active ? tx_shift[DATA_WIDTH-1] : 1'b0;
    assign bus.tx_ready = init_done & ~tx_full;
    assign bus.rx_data  = rx_data_r;
    assign bus.rx_valid = rx_valid_r;
    assign bus.busy     = cs_armed & ~cs_s;
endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - scoreboard bench for spi_slave in all four SPI modes
module tb_spi_slave;
    localparam time HALF = 100ns;

    logic       clk;
    logic       rst;
    logic [3:0] sclk;
    logic [3:0] cs_n;
    logic [3:0] mosi;
    logic [3:0] tx_valid;
    logic [3:0] rx_ack;
    logic [3:0] ack_en;
    logic [7:0] tx_data [4];

    logic       miso_a     [4];
    logic       tx_ready_a [4];
    logic       rx_valid_a [4];
    logic       busy_a     [4];
    logic [7:0] rx_data_a  [4];
`ifdef SPI_SLAVE_OVERRUN_EN
    logic       ovr_a      [4];
`endif

    int n_chk = 0;
    int n_err = 0;
    logic [9:0] rx_q [$];
    logic [7:0] mst_q [$];

    initial clk = 1'b0;
    always #10 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_mode
        spi_slave_if #(.DATA_WIDTH(8)) bus ();

        assign bus.sclk     = sclk[g];
        assign bus.cs_n     = cs_n[g];
        assign bus.mosi     = mosi[g];
        assign bus.tx_data  = tx_data[g];
        assign bus.tx_valid = tx_valid[g];
        assign bus.rx_ack   = rx_ack[g];
        assign miso_a[g]     = bus.miso;
        assign tx_ready_a[g] = bus.tx_ready;
        assign rx_valid_a[g] = bus.rx_valid;
        assign busy_a[g]     = bus.busy;
        assign rx_data_a[g]  = bus.rx_data;
`ifdef SPI_SLAVE_OVERRUN_EN
        assign ovr_a[g]      = bus.overrun;
`endif

        spi_slave #(
            .DATA_WIDTH (8),
            .CPOL       ((g >> 1) & 1),
            .CPHA       (g & 1),
            .SYNC_STAGES(2)
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus.slave)
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input int m);
        check("rst_miso", miso_a[m], 0);
        check("rst_rx_data", rx_data_a[m], 0);
        check("rst_rx_valid", rx_valid_a[m], 0);
        check("rst_tx_ready", tx_ready_a[m], 0);
        check("rst_busy", busy_a[m], 0);
`ifdef SPI_SLAVE_OVERRUN_EN
        check("rst_overrun", ovr_a[m], 0);
`endif
    endtask

    task automatic write_tx(input int m, input logic [7:0] d);
        @(negedge clk);
        tx_data[m]  = d;
        tx_valid[m] = 1'b1;
        @(negedge clk);
        tx_valid[m] = 1'b0;
        mst_q.push_back(d);
    endtask

    task automatic cs_low(input int m);
        cs_n[m] = 1'b0;
        #(2 * HALF);
    endtask

    task automatic cs_high(input int m);
        #HALF;
        cs_n[m] = 1'b1;
        #(2 * HALF);
    endtask

    task automatic send_word(input int m, input logic [7:0] d, input int nbits,
                             input bit exp_rx, input bit cmp_mst);
        logic [7:0] got;
        logic       cpol;
        got  = 8'h00;
        cpol = ((m >> 1) & 1) != 0;
        if (exp_rx) rx_q.push_back({m[1:0], d});
        for (int i = 0; i < nbits; i++) begin
            if ((m & 1) == 0) begin
                mosi[m] = d[7-i];
                #HALF;
                got = {got[6:0], miso_a[m]};
                sclk[m] = ~cpol;
                #HALF;
                sclk[m] = cpol;
            end else begin
                sclk[m] = ~cpol;
                mosi[m] = d[7-i];
                #HALF;
                got = {got[6:0], miso_a[m]};
                sclk[m] = cpol;
                #HALF;
            end
        end
        if (cmp_mst) begin
            if (mst_q.size() == 0) check("mst_rx_unexpected", got, 8'hxx);
            else check("mst_rx", got, mst_q.pop_front());
        end
    endtask

    // Slave-side monitor: pop the scoreboard on each rx_valid, then acknowledge
    initial begin
        rx_ack = 4'h0;
        forever begin
            @(negedge clk);
            for (int m = 0; m < 4; m++) begin
                if (rx_ack[m]) begin
                    rx_ack[m] = 1'b0;
                end else if (rx_valid_a[m] && ack_en[m]) begin
                    if (rx_q.size() == 0) check("slv_rx_unexpected", rx_valid_a[m], 0);
                    else check("slv_rx", {m[1:0], rx_data_a[m]}, rx_q.pop_front());
                    rx_ack[m] = 1'b1;
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        cs_n     = 4'hF;
        sclk     = 4'b1100;
        mosi     = 4'h0;
        tx_valid = 4'h0;
        ack_en   = 4'hF;
        for (int m = 0; m < 4; m++) tx_data[m] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int m = 0; m < 4; m++) check_reset_values(m);
        rst = 1'b0;
        @(negedge clk);
        for (int m = 0; m < 4; m++) check("tx_ready_after_rst", tx_ready_a[m], 1);
        repeat (5) @(negedge clk);

        // Basic exchange, default mode first, then the other three
        for (int m = 3; m >= 0; m--) begin
            write_tx(m, 8'h3C);
            check("tx_ready_full", tx_ready_a[m], 0);
            cs_low(m);
            check("tx_ready_after_cs", tx_ready_a[m], 1);
            check("busy_in_frame", busy_a[m], 1);
            send_word(m, 8'hA5, 8, 1, 1);
            cs_high(m);
            check("busy_after_frame", busy_a[m], 0);
        end

        // Underrun: nothing loaded, master reads all ones
        mst_q.push_back(8'hFF);
        cs_low(3);
        send_word(3, 8'h9A, 8, 1, 1);
        cs_high(3);

        // Burst of two words within one chip select
        write_tx(3, 8'h11);
        cs_low(3);
        write_tx(3, 8'h22);
        send_word(3, 8'hA5, 8, 1, 1);
        send_word(3, 8'h9A, 8, 1, 1);
        cs_high(3);

        // Abort after 3 bits, then a clean frame
        cs_low(3);
        send_word(3, 8'hE7, 3, 0, 0);
        cs_high(3);
        check("abort_no_rx_valid", rx_valid_a[3], 0);
        mst_q.push_back(8'hFF);
        cs_low(3);
        send_word(3, 8'h5A, 8, 1, 1);
        cs_high(3);

        // Two words without acknowledge: second word overwrites the first
        ack_en[3] = 1'b0;
        mst_q.push_back(8'hFF);
        mst_q.push_back(8'hFF);
        cs_low(3);
        send_word(3, 8'h12, 8, 0, 1);
        send_word(3, 8'h34, 8, 0, 1);
        cs_high(3);
        check("noack_rx_valid", rx_valid_a[3], 1);
        check("noack_rx_data", rx_data_a[3], 8'h34);
`ifdef SPI_SLAVE_OVERRUN_EN
        check("overrun_set", ovr_a[3], 1);
`endif

        // Reset in the middle of a frame; the rest of that frame is ignored
        cs_low(3);
        send_word(3, 8'hF0, 3, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values(3);
        rst = 1'b0;
        send_word(3, 8'hF0, 5, 0, 0);
        cs_high(3);
        check("post_rst_rx_valid", rx_valid_a[3], 0);
        check("post_rst_tx_ready", tx_ready_a[3], 1);
        ack_en[3] = 1'b1;

        // Recovery frame
        write_tx(3, 8'hC3);
        cs_low(3);
        send_word(3, 8'h7E, 8, 1, 1);
        cs_high(3);

        repeat (10) @(negedge clk);
        check("rx_q_drained", rx_q.size(), 0);
        check("mst_q_drained", mst_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
